// File: rtl/contactor_scheduler_pkg.sv
// Shared types for the contactor scheduler: feedback codes and FSM state encoding.
package contactor_scheduler_pkg;

    localparam logic [1:0] FB_OPEN   = 2'b01;
    localparam logic [1:0] FB_CLOSED = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT_FB,
        SETTLE
    } sched_state_t;

    // Counter width helper that never returns zero for tiny parameters.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/contactor_scheduler_if.sv
// Request/feedback/drive bundle between spi_slave, the scheduler and the contactor drivers.
interface contactor_scheduler_if #(
    parameter int N_CONT = 21
);
    localparam int IDX_W = (N_CONT > 1) ? $clog2(N_CONT) : 1;

    logic [N_CONT-1:0]   spi_requests;
    logic [2*N_CONT-1:0] router_feedback;
    logic                shutdown_any;
    logic                clear_errors;
    logic [N_CONT-1:0]   contactor_drive;
    logic [N_CONT-1:0]   contactor_status;
    logic                feedback_timeout_error;
    logic                invalid_request;
    logic                busy;
    logic [IDX_W-1:0]    active_idx;

    modport master (
        output spi_requests, router_feedback, shutdown_any, clear_errors,
        input  contactor_drive, contactor_status, feedback_timeout_error,
               invalid_request, busy, active_idx
    );

    modport slave (
        input  spi_requests, router_feedback, shutdown_any, clear_errors,
        output contactor_drive, contactor_status, feedback_timeout_error,
               invalid_request, busy, active_idx
    );
endinterface

// File: rtl/contactor_scheduler_sync_2ff.sv
// Two-flop synchronizer, per-bit, for quasi-static multi-bit levels.
// Latency 2 clk; no backpressure.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/contactor_scheduler.sv
// Serialises contactor open/close changes one index at a time with feedback check, timeout and settle.
// Latency: request visible to scan after 2 clk; one index examined per clk while scanning.
module contactor_scheduler
    import contactor_scheduler_pkg::*;
#(
    parameter int N_CONT      = 21,
    parameter int MAX_CLOSED  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int SETTLE_CYC  = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    contactor_scheduler_if.slave bus
);
    localparam int IDX_W = (N_CONT > 1) ? $clog2(N_CONT) : 1;
    localparam int TMO_W = clog2_min1(TIMEOUT_CYC);
    localparam int STL_W = clog2_min1(SETTLE_CYC);
    localparam int PC_W  = $clog2(N_CONT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CONT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE_CYC - 1);
    localparam logic [PC_W-1:0]  MAX_C    = PC_W'(MAX_CLOSED);

    sched_state_t      state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt, idx, idx_nxt, ptr_inc, idx_inc;
    logic [TMO_W-1:0]  timer, timer_nxt;
    logic [STL_W-1:0]  settle_cnt, settle_nxt;
    logic [N_CONT-1:0] drive, drive_nxt, status, status_nxt, req_s;
    logic              timeout_err, invalid_err, set_tmo, set_inv;
    logic [PC_W-1:0]   closed_cnt;
    logic [1:0]        fb_pair, fb_expect;

    sync_2ff #(.WIDTH(N_CONT)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.spi_requests),
        .q     (req_s)
    );

    always_comb begin
        closed_cnt = '0;
        for (int i = 0; i < N_CONT; i++) closed_cnt = closed_cnt + PC_W'(drive[i]);
    end

    assign fb_pair   = bus.router_feedback[{idx, 1'b0} +: 2];
    assign fb_expect = drive[idx] ? FB_CLOSED : FB_OPEN;
    assign ptr_inc   = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
    assign idx_inc   = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        idx_nxt    = idx;
        timer_nxt  = timer;
        settle_nxt = settle_cnt;
        drive_nxt  = drive;
        status_nxt = status;
        set_tmo    = 1'b0;
        set_inv    = 1'b0;

        case (state)
            IDLE: state_nxt = SCAN;
            SCAN: begin
                if (req_s[ptr] != drive[ptr]) begin
                    // Opens are always allowed; closes are gated by the inrush limit and by a past timeout.
                    if (!drive[ptr] && closed_cnt >= MAX_C) begin
                        set_inv = 1'b1;
                        ptr_nxt = ptr_inc;
                    end else if (!drive[ptr] && timeout_err) begin
                        ptr_nxt = ptr_inc;
                    end else begin
                        drive_nxt[ptr] = ~drive[ptr];
                        idx_nxt        = ptr;
                        timer_nxt      = '0;
                        state_nxt      = WAIT_FB;
                    end
                end else begin
                    ptr_nxt = ptr_inc;
                end
            end
            WAIT_FB: begin
                if (fb_pair == fb_expect) begin
                    status_nxt[idx] = drive[idx];
                    timer_nxt       = '0;
                    settle_nxt      = '0;
                    state_nxt       = SETTLE;
                end else if (timer == TMO_LAST) begin
                    set_tmo         = 1'b1;
                    drive_nxt[idx]  = 1'b0;
                    status_nxt[idx] = 1'b0;
                    timer_nxt       = '0;
                    settle_nxt      = '0;
                    state_nxt       = SETTLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt == STL_LAST) begin
                    ptr_nxt   = idx_inc;
                    state_nxt = SCAN;
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (bus.shutdown_any) begin
            state_nxt  = IDLE;
            drive_nxt  = '0;
            status_nxt = '0;
            timer_nxt  = '0;
            settle_nxt = '0;
            set_tmo    = 1'b0;
            set_inv    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            idx         <= '0;
            timer       <= '0;
            settle_cnt  <= '0;
            drive       <= '0;
            status      <= '0;
            timeout_err <= 1'b0;
            invalid_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            idx         <= idx_nxt;
            timer       <= timer_nxt;
            settle_cnt  <= settle_nxt;
            drive       <= drive_nxt;
            status      <= status_nxt;
            // A flag raised in the same cycle as a clear survives the clear.
            timeout_err <= (timeout_err & ~bus.clear_errors) | set_tmo;
            invalid_err <= (invalid_err & ~bus.clear_errors) | set_inv;
        end
    end

    assign bus.contactor_drive        = drive;
    assign bus.contactor_status       = status;
    assign bus.feedback_timeout_error = timeout_err;
    assign bus.invalid_request        = invalid_err;
    assign bus.busy                   = (state == WAIT_FB) || (state == SETTLE);
    assign bus.active_idx             = idx;
endmodule

// File: tb/tb_contactor_scheduler.sv
// Directed bench for contactor_scheduler with a delayed-echo router feedback model.
module tb_contactor_scheduler;
    localparam int N    = 21;
    localparam int MAXC = 3;
    localparam int TMO  = 40;
    localparam int STL  = 8;
    localparam int FBD  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    contactor_scheduler_if #(.N_CONT(N)) bus_if ();

    contactor_scheduler #(
        .N_CONT(N), .MAX_CLOSED(MAXC), .TIMEOUT_CYC(TMO), .SETTLE_CYC(STL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Router echoes the drive FBD cycles later; stuck contactors always report open.
    logic [N-1:0] stuck = '0;
    logic [N-1:0] fb_pipe [FBD] = '{default: '0};
    always @(posedge clk) begin
        fb_pipe[0] <= bus_if.contactor_drive;
        for (int k = 1; k < FBD; k++) fb_pipe[k] <= fb_pipe[k-1];
    end
    always_comb begin
        bus_if.router_feedback = '0;
        for (int i = 0; i < N; i++)
            bus_if.router_feedback[2*i +: 2] = (!stuck[i] && fb_pipe[FBD-1][i] === 1'b1) ? 2'b10 : 2'b01;
    end

    // Change log of drive transitions outside reset/shutdown.
    int cyc = 0;
    logic skip_chg = 1'b1;
    logic [N-1:0] prev_drive = '0;
    logic [N-1:0] diff;
    int chg_idx[$];
    int chg_cyc[$];
    int multi_chg = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        skip_chg <= !rst_n || bus_if.shutdown_any;
    end
    always @(negedge clk) begin
        diff = bus_if.contactor_drive ^ prev_drive;
        if (!skip_chg && diff != '0) begin
            if ($countones(diff) > 1) multi_chg++;
            else for (int k = 0; k < N; k++) if (diff[k]) begin
                chg_idx.push_back(k);
                chg_cyc.push_back(cyc);
            end
        end
        prev_drive = bus_if.contactor_drive;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        chg_idx.delete();
        chg_cyc.delete();
        multi_chg = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.spi_requests = '0;
        bus_if.shutdown_any = 1'b0;
        bus_if.clear_errors = 1'b0;
        stuck = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset, then hold shutdown while requests synchronise so scanning starts at index 0.
    task automatic start_clean(input logic [N-1:0] req);
        do_reset();
        bus_if.shutdown_any = 1'b1;
        bus_if.spi_requests = req;
        repeat (3) @(negedge clk);
        clear_log();
        bus_if.shutdown_any = 1'b0;
    endtask

    task automatic test_reset();
        bus_if.spi_requests = '0;
        bus_if.shutdown_any = 1'b0;
        bus_if.clear_errors = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus_if.contactor_drive !== '0) begin n_bad++; $display("FAIL reset_drive: got %h want 0", bus_if.contactor_drive); end
        n_cmp++; if (bus_if.contactor_status !== '0) begin n_bad++; $display("FAIL reset_status: got %h want 0", bus_if.contactor_status); end
        n_cmp++; if (bus_if.feedback_timeout_error !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b want 0", bus_if.feedback_timeout_error); end
        n_cmp++; if (bus_if.invalid_request !== 1'b0) begin n_bad++; $display("FAIL reset_inv: got %b want 0", bus_if.invalid_request); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        n_cmp++; if (bus_if.active_idx !== '0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", bus_if.active_idx); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_close();
        int t;
        do_reset();
        bus_if.spi_requests = 21'h8;
        t = 0;
        while (!bus_if.contactor_drive[3] && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (t != 5) begin n_bad++; $display("FAIL close_latency: got %0d want 5 cycles", t); end
        n_cmp++; if (bus_if.active_idx !== 5'd3) begin n_bad++; $display("FAIL close_idx: got %0d want 3", bus_if.active_idx); end
        n_cmp++; if (bus_if.busy !== 1'b1 || bus_if.contactor_status[3] !== 1'b0) begin n_bad++; $display("FAIL close_wait: busy %b status %b want 1 0", bus_if.busy, bus_if.contactor_status[3]); end
        t = 0;
        while (!bus_if.contactor_status[3] && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (t != FBD + 1) begin n_bad++; $display("FAIL confirm_latency: got %0d want %0d", t, FBD + 1); end
        t = 0;
        while (bus_if.busy && t < 100) begin t++; @(negedge clk); end
        n_cmp++; if (t != STL) begin n_bad++; $display("FAIL settle_len: got %0d want %0d", t, STL); end
        n_cmp++; if (bus_if.contactor_drive !== 21'h8 || bus_if.contactor_status !== 21'h8) begin n_bad++; $display("FAIL close_final: drive %h status %h want 8 8", bus_if.contactor_drive, bus_if.contactor_status); end
    endtask

    task automatic test_order();
        int t;
        logic [N-1:0] tgt;
        tgt = 21'h100021;
        start_clean(tgt);
        t = 0;
        while ((bus_if.contactor_status !== tgt || bus_if.busy) && t < 400) begin @(negedge clk); t++; end
        n_cmp++; if (t >= 400) begin n_bad++; $display("FAIL order_done: status %h want %h", bus_if.contactor_status, tgt); end
        n_cmp++; if (chg_idx.size() != 3) begin n_bad++; $display("FAIL order_count: got %0d want 3", chg_idx.size()); end
        else begin
            n_cmp++; if (chg_idx[0] != 0 || chg_idx[1] != 5 || chg_idx[2] != 20) begin n_bad++; $display("FAIL order_seq: got %0d %0d %0d want 0 5 20", chg_idx[0], chg_idx[1], chg_idx[2]); end
            n_cmp++; if (chg_cyc[1] - chg_cyc[0] != 18) begin n_bad++; $display("FAIL order_gap1: got %0d want 18", chg_cyc[1] - chg_cyc[0]); end
            n_cmp++; if (chg_cyc[2] - chg_cyc[1] != 28) begin n_bad++; $display("FAIL order_gap2: got %0d want 28", chg_cyc[2] - chg_cyc[1]); end
        end
        n_cmp++; if (multi_chg != 0) begin n_bad++; $display("FAIL order_multi: got %0d want 0", multi_chg); end
        n_cmp++; if (bus_if.contactor_drive !== tgt || bus_if.invalid_request !== 1'b0) begin n_bad++; $display("FAIL order_final: drive %h inv %b want %h 0", bus_if.contactor_drive, bus_if.invalid_request, tgt); end
    endtask

    task automatic test_limit();
        bus_if.spi_requests = 21'h100023;
        repeat (60) @(negedge clk);
        n_cmp++; if (bus_if.invalid_request !== 1'b1) begin n_bad++; $display("FAIL limit_flag: got %b want 1", bus_if.invalid_request); end
        n_cmp++; if (bus_if.contactor_drive !== 21'h100021 || chg_idx.size() != 3) begin n_bad++; $display("FAIL limit_drive: drive %h changes %0d want 100021 3", bus_if.contactor_drive, chg_idx.size()); end
        bus_if.spi_requests = 21'h100021;
        repeat (30) @(negedge clk);
        n_cmp++; if (bus_if.invalid_request !== 1'b1) begin n_bad++; $display("FAIL limit_sticky: got %b want 1", bus_if.invalid_request); end
        bus_if.clear_errors = 1'b1;
        @(negedge clk);
        bus_if.clear_errors = 1'b0;
        n_cmp++; if (bus_if.invalid_request !== 1'b0) begin n_bad++; $display("FAIL limit_clear: got %b want 0", bus_if.invalid_request); end
    endtask

    task automatic test_timeout();
        int t;
        start_clean(21'h4);
        t = 0;
        while (!bus_if.contactor_status[2] && t < 100) begin @(negedge clk); t++; end
        n_cmp++; if (t >= 100) begin n_bad++; $display("FAIL tmo_pre_close: status %h want bit2", bus_if.contactor_status); end
        stuck[4] = 1'b1;
        bus_if.spi_requests = 21'h14;
        t = 0;
        while (!bus_if.contactor_drive[4] && t < 100) begin @(negedge clk); t++; end
        t = 0;
        while (bus_if.contactor_drive[4] && t < 200) begin t++; @(negedge clk); end
        n_cmp++; if (t != TMO) begin n_bad++; $display("FAIL tmo_len: got %0d want %0d", t, TMO); end
        n_cmp++; if (bus_if.feedback_timeout_error !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", bus_if.feedback_timeout_error); end
        n_cmp++; if (bus_if.contactor_status !== 21'h4 || bus_if.contactor_drive !== 21'h4) begin n_bad++; $display("FAIL tmo_state: drive %h status %h want 4 4", bus_if.contactor_drive, bus_if.contactor_status); end
        bus_if.spi_requests = 21'h54;
        repeat (80) @(negedge clk);
        n_cmp++; if (bus_if.contactor_drive[6] !== 1'b0 || bus_if.invalid_request !== 1'b0) begin n_bad++; $display("FAIL tmo_skip: drive6 %b inv %b want 0 0", bus_if.contactor_drive[6], bus_if.invalid_request); end
        bus_if.spi_requests = 21'h50;
        t = 0;
        while ((bus_if.contactor_drive[2] || bus_if.contactor_status[2]) && t < 100) begin @(negedge clk); t++; end
        n_cmp++; if (t >= 100) begin n_bad++; $display("FAIL tmo_open: drive %h status %h want bit2 clear", bus_if.contactor_drive, bus_if.contactor_status); end
        n_cmp++; if (bus_if.feedback_timeout_error !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", bus_if.feedback_timeout_error); end
    endtask

    task automatic test_shutdown();
        int t;
        start_clean(21'h6);
        t = 0;
        while ((bus_if.contactor_status !== 21'h6 || bus_if.busy) && t < 200) begin @(negedge clk); t++; end
        bus_if.spi_requests = 21'h206;
        t = 0;
        while (!bus_if.contactor_drive[9] && t < 100) begin @(negedge clk); t++; end
        n_cmp++; if (t >= 100) begin n_bad++; $display("FAIL sd_pre: drive %h want bit9", bus_if.contactor_drive); end
        bus_if.shutdown_any = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_if.contactor_drive !== '0 || bus_if.contactor_status !== '0) begin n_bad++; $display("FAIL sd_clear: drive %h status %h want 0 0", bus_if.contactor_drive, bus_if.contactor_status); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL sd_busy: got %b want 0", bus_if.busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (bus_if.contactor_drive !== '0 || bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL sd_hold: drive %h busy %b want 0 0", bus_if.contactor_drive, bus_if.busy); end
        clear_log();
        bus_if.shutdown_any = 1'b0;
        t = 0;
        while ((bus_if.contactor_status !== 21'h206 || bus_if.busy) && t < 400) begin @(negedge clk); t++; end
        n_cmp++; if (chg_idx.size() != 3) begin n_bad++; $display("FAIL sd_recount: got %0d want 3", chg_idx.size()); end
        else begin
            n_cmp++; if (chg_idx[0] != 9 || chg_idx[1] != 1 || chg_idx[2] != 2) begin n_bad++; $display("FAIL sd_reorder: got %0d %0d %0d want 9 1 2", chg_idx[0], chg_idx[1], chg_idx[2]); end
        end
        n_cmp++; if (multi_chg != 0 || bus_if.contactor_drive !== 21'h206) begin n_bad++; $display("FAIL sd_final: multi %0d drive %h want 0 206", multi_chg, bus_if.contactor_drive); end
    endtask

    task automatic test_reset_settle();
        int t;
        start_clean(21'h400);
        t = 0;
        while (!bus_if.contactor_status[10] && t < 100) begin @(negedge clk); t++; end
        bus_if.spi_requests = 21'h8400;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus_if.contactor_drive !== '0 || bus_if.contactor_status !== '0) begin n_bad++; $display("FAIL rs_outputs: drive %h status %h want 0 0", bus_if.contactor_drive, bus_if.contactor_status); end
        n_cmp++; if (bus_if.busy !== 1'b0 || bus_if.active_idx !== '0) begin n_bad++; $display("FAIL rs_fsm: busy %b idx %0d want 0 0", bus_if.busy, bus_if.active_idx); end
        rst_n = 1'b1;
        clear_log();
        t = 0;
        while ((bus_if.contactor_status !== 21'h8400 || bus_if.busy) && t < 400) begin @(negedge clk); t++; end
        n_cmp++; if (chg_idx.size() != 2) begin n_bad++; $display("FAIL rs_count: got %0d want 2", chg_idx.size()); end
        else begin
            n_cmp++; if (chg_idx[0] != 10 || chg_idx[1] != 15) begin n_bad++; $display("FAIL rs_order: got %0d %0d want 10 15", chg_idx[0], chg_idx[1]); end
        end
    endtask

    initial begin
        bus_if.spi_requests = '0;
        bus_if.shutdown_any = 1'b0;
        bus_if.clear_errors = 1'b0;
        test_reset();
        test_single_close();
        test_order();
        test_limit();
        test_timeout();
        test_shutdown();
        test_reset_settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/contactor_scheduler.md
Name: contactor_scheduler

Overview:
Sequences SPI-requested contactor state changes one contactor at a time on the system clock. Each change is verified against router feedback, with timeout and settle handling. Sits between spi_slave (spi_requests, control_out.clear_errors, spi_shutdown_cmd) and the contactor drivers. Returns contactor_status and the status_reg_t error bits (feedback_timeout_error, invalid_request) to spi_slave.

Parameters:
N_CONT, 21, number of contactors; index width IDX_W = $clog2(N_CONT).
MAX_CLOSED, 8, maximum contactors driven closed at once (inrush limit).
TIMEOUT_CYC, 50000, clk cycles allowed for feedback to confirm a change.
SETTLE_CYC, 1000, clk cycles of dead time after each confirmed change.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
spi_requests  in  N_CONT  requested state per contactor (1 = closed), sclk domain
router_feedback  in  2*N_CONT  per-contactor feedback pair [2i+:2]: 01 = open, 10 = closed, 00/11 = invalid
shutdown_any  in  1  OR of spi_shutdown_cmd and thermal shutdown; level, clk domain
clear_errors  in  1  clears sticky error flags; level, sampled each cycle
contactor_drive  out  N_CONT  coil drive
contactor_status  out  N_CONT  confirmed-closed state per contactor
feedback_timeout_error  out  1  sticky
invalid_request  out  1  sticky
busy  out  1  high in any state other than IDLE/SCAN
active_idx  out  IDX_W  index currently being changed

Behaviour:
- Reset (clk edge with rst_n = 0): all outputs 0, FSM = IDLE, scan pointer = 0, counters = 0, synchronizers = 0.
- spi_requests is double-flopped per bit into req_s. Latency from request to first scan visibility is 2 clk.
- States: IDLE, SCAN, WAIT_FB, SETTLE.
- IDLE: go to SCAN next cycle whenever shutdown_any = 0.
- SCAN: examine one index per cycle, starting at ptr. Mismatch means req_s[ptr] != contactor_drive[ptr].
  - Opening (drive 1 -> 0): always granted.
  - Closing: granted only if popcount(contactor_drive) < MAX_CLOSED and feedback_timeout_error = 0.
  - Refused close due to limit: set invalid_request, advance ptr, stay in SCAN.
  - Refused close due to error: advance ptr silently.
  - Granted: toggle contactor_drive[ptr], active_idx = ptr, clear timer, go to WAIT_FB.
  - No mismatch: advance ptr.
  - ptr wraps N_CONT-1 -> 0.
- WAIT_FB: timer increments each cycle.
  - Feedback equal to the expected code (10 closed / 01 open) for the index: contactor_status[idx] = drive[idx], clear timer, go to SETTLE.
  - Timer reaches TIMEOUT_CYC-1 without match: set feedback_timeout_error. If the change was a close, clear drive[idx]. contactor_status[idx] = 0. Go to SETTLE.
  - Feedback of 00/11 is not a match and does not end the wait early.
- SETTLE: count SETTLE_CYC cycles, then ptr = idx+1 (wrapped) and return to SCAN. This gives round-robin fairness.
- Request withdrawn during WAIT_FB/SETTLE: no abort. The reversal is handled on a later scan.
- shutdown_any = 1, any state: next cycle contactor_drive = 0, contactor_status = 0, FSM = IDLE, timer cleared. Remains in IDLE while shutdown_any = 1. Error flags are unaffected.
- clear_errors = 1: both sticky flags are 0 next cycle. If the same cycle sets a flag, the set wins.
- Counter widths are sized by $clog2 of their parameter. Popcount covers N_CONT bits.

Decomposition:
- spi_pkg gains: the feedback code constants FB_OPEN = 2'b01 and FB_CLOSED = 2'b10, and the sched_state_t enum (IDLE, SCAN, WAIT_FB, SETTLE).
- One sub-module, sync_2ff: parameterised width, 2-flop synchronizer for spi_requests.

Test Plan:
- Reset, then spi_requests[3] = 1 with feedback[7:6] going to 10 after 10 cycles -> drive[3] = 1 within 3 cycles of SCAN reaching idx 3; status[3] = 1 after feedback; busy drops after SETTLE_CYC.
- Requests 0, 5 and 20 raised simultaneously -> changes issued strictly in order 0, 5, 20, each separated by confirm plus SETTLE_CYC; never two drive bits changing in one cycle.
- MAX_CLOSED = 2, requests 0, 1, 2 -> drive = 0b011, invalid_request = 1, drive[2] never asserts; clear_errors pulse -> flag 0.
- Close idx 4 with feedback held at 01 -> after TIMEOUT_CYC: feedback_timeout_error = 1, drive[4] = 0, status[4] = 0; a further close on idx 6 is skipped; an open on an already-closed idx still proceeds.
- Six contactors closed, then shutdown_any pulse mid-WAIT_FB -> drive = 0 and status = 0 next cycle, FSM in IDLE; after release, still-requested contactors re-close one by one.
- rst_n low for 1 cycle during SETTLE -> all outputs 0 on the next edge; sequencing restarts from idx 0.
